xil_mm_bridge: RTL and testbench

// Bridges Xillybus 32-bit request/response FIFO streams to a single-master register bus with delayed response.

---
 rtl/xil_mm_bridge.sv | 147 ++++++++++++++
 tb/tb_xil_mm_bridge.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xil_mm_bridge.sv
// Xillybus request/response FIFO streams to a single-master register bus.
// Word pairs become one bus transaction; each transaction returns two response words.
module xil_mm_bridge #(
    parameter int ADDR_WIDTH = 24,
    parameter int RESP_DEPTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           req_data,
    input  logic                  req_wren,
    output logic                  req_full,
    input  logic                  req_open,
    output logic [31:0]           resp_data,
    input  logic                  resp_rden,
    output logic                  resp_empty,
    input  logic                  resp_open,
    output logic                  reg_valid,
    output logic                  reg_wr,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [31:0]           reg_wdata,
    input  logic                  reg_ack,
    input  logic [31:0]           reg_rdata,
    output logic [15:0]           timeout_cnt,
    output logic [15:0]           ovf_cnt
);

    localparam int PW = $clog2(RESP_DEPTH);

    typedef enum logic [2:0] {IDLE, W1, ISSUE, RESP0, RESP1} state_t;

    state_t      state;
    logic [PW:0] wptr;
    logic [PW:0] rptr;
    logic [PW:0] used;
    logic [31:0] mem [RESP_DEPTH];
    logic [15:0] tmr;
    logic        to_flag;
    logic [31:0] rdata_q;
    logic        room;
    logic        accept;
    logic        push;
    logic        pop;
    logic [31:0] push_word;
    logic        unused_bits;

    assign unused_bits = ^req_data[30:ADDR_WIDTH];

    // IDLE only admits a new pair when both response words are guaranteed a slot.
    assign used       = wptr - rptr;
    assign room       = used <= (PW+1)'(RESP_DEPTH - 2);
    assign resp_empty = (wptr == rptr);
    assign req_full   = (state == ISSUE) || (state == RESP0) || (state == RESP1) ||
                        ((state == IDLE) && !room);
    assign accept     = req_wren && req_open && !req_full;
    assign pop        = resp_rden && resp_open && !resp_empty;
    assign push       = resp_open && ((state == RESP0) || (state == RESP1));
    assign push_word  = (state == RESP0) ? {to_flag, reg_wr, 30'(reg_addr)} : rdata_q;

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr[PW-1:0]] <= push_word;
    end

    // A closed response file flushes the FIFO continuously.
    always_ff @(posedge clk) begin
        if (!rst_n || !resp_open) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            resp_data <= 32'h0;
        else if (pop)
            resp_data <= mem[rptr[PW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            ovf_cnt <= 16'h0;
        else if (req_wren && req_full && (ovf_cnt != 16'hFFFF))
            ovf_cnt <= ovf_cnt + 16'h1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            reg_valid   <= 1'b0;
            reg_wr      <= 1'b0;
            reg_addr    <= '0;
            reg_wdata   <= 32'h0;
            tmr         <= 16'h0;
            to_flag     <= 1'b0;
            rdata_q     <= 32'h0;
            timeout_cnt <= 16'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        reg_wr   <= req_data[31];
                        reg_addr <= req_data[ADDR_WIDTH-1:0];
                        state    <= W1;
                    end
                end
                W1: begin
                    if (!req_open) begin
                        state <= IDLE;
                    end else if (accept) begin
                        reg_wdata <= req_data;
                        reg_valid <= 1'b1;
                        tmr       <= 16'h0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Ack wins over a timeout landing on the same cycle.
                    if (reg_ack) begin
                        reg_valid <= 1'b0;
                        to_flag   <= 1'b0;
                        rdata_q   <= reg_wr ? reg_wdata : reg_rdata;
                        state     <= RESP0;
                    end else if (tmr == 16'(TIMEOUT - 1)) begin
                        reg_valid <= 1'b0;
                        to_flag   <= 1'b1;
                        rdata_q   <= 32'hDEAD_DEAD;
                        if (timeout_cnt != 16'hFFFF)
                            timeout_cnt <= timeout_cnt + 16'h1;
                        state     <= RESP0;
                    end else begin
                        tmr <= tmr + 16'h1;
                    end
                end
                RESP0:   state <= RESP1;
                RESP1:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xil_mm_bridge.sv
// Bench for xil_mm_bridge: directed vector table, randomized transactions against a
// queue-based response model, and hand-written backpressure/abort/close sequences.
module tb_xil_mm_bridge;

    localparam int AW    = 24;
    localparam int DEPTH = 16;
    localparam int TMO   = 255;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   req_data;
    logic          req_wren;
    logic          req_full;
    logic          req_open;
    logic [31:0]   resp_data;
    logic          resp_rden;
    logic          resp_empty;
    logic          resp_open;
    logic          reg_valid;
    logic          reg_wr;
    logic [AW-1:0] reg_addr;
    logic [31:0]   reg_wdata;
    logic          reg_ack;
    logic [31:0]   reg_rdata;
    logic [15:0]   timeout_cnt;
    logic [15:0]   ovf_cnt;

    always #5 clk = ~clk;

    xil_mm_bridge #(.ADDR_WIDTH(AW), .RESP_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_data(req_data), .req_wren(req_wren), .req_full(req_full), .req_open(req_open),
        .resp_data(resp_data), .resp_rden(resp_rden), .resp_empty(resp_empty), .resp_open(resp_open),
        .reg_valid(reg_valid), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_ack(reg_ack), .reg_rdata(reg_rdata),
        .timeout_cnt(timeout_cnt), .ovf_cnt(ovf_cnt)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        int          dly;
        logic [31:0] rd;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vt[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response words computed straight from the transaction rules.
    function automatic logic [31:0] model_w0(input logic [31:0] w0, input bit to);
        logic [31:0] mask;
        mask = (32'h1 << AW) - 32'h1;
        return {to, w0[31], 30'd0} | (w0 & mask);
    endfunction

    function automatic logic [31:0] model_w1(input logic [31:0] w0, input logic [31:0] w1,
                                             input logic [31:0] rd, input bit to);
        if (to) return 32'hDEAD_DEAD;
        return w0[31] ? w1 : rd;
    endfunction

    // Entered and left right after a falling edge.
    task automatic run_txn(input logic [31:0] w0, input logic [31:0] w1, input int dly,
                           input logic [31:0] rd, input bit expect_resp);
        bit was_empty;
        bit to;
        int cnt;
        was_empty = resp_empty;
        to        = (dly < 0);
        req_wren  = 1'b1;
        req_data  = w0;
        @(negedge clk);
        req_data  = w1;
        @(negedge clk);
        req_wren  = 1'b0;
        req_data  = 32'h0;
        check("valid_rise", reg_valid, 1);
        check("reg_wr", reg_wr, w0[31]);
        check("reg_addr", reg_addr, w0[AW-1:0]);
        check("reg_wdata", reg_wdata, w1);
        if (!to) begin
            for (int i = 0; i < dly; i++) @(negedge clk);
            check("valid_hold", reg_valid, 1);
            reg_ack   = 1'b1;
            reg_rdata = rd;
            @(negedge clk);
            reg_ack   = 1'b0;
            reg_rdata = 32'h0;
            check("valid_drop", reg_valid, 0);
        end else begin
            cnt = 0;
            while (reg_valid && cnt < 1000) begin
                cnt++;
                @(negedge clk);
            end
            check("valid_cycles", cnt, TMO);
        end
        @(negedge clk);
        if (was_empty && expect_resp) check("empty_fall", resp_empty, 0);
        @(negedge clk);
    endtask

    task automatic read_word(output logic [31:0] d);
        resp_rden = 1'b1;
        @(negedge clk);
        resp_rden = 1'b0;
        d = resp_data;
    endtask

    task automatic check_pop(input string name);
        logic [31:0] d;
        logic [31:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
        read_word(d);
        check(name, d, e);
    endtask

    task automatic model_push(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] rd, input bit to);
        exp_q.push_back(model_w0(w0, to));
        exp_q.push_back(model_w1(w0, w1, rd, to));
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] prev;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] rd;
        int          dly;

        rst_n = 1'b0; req_data = 32'h0; req_wren = 1'b0; req_open = 1'b1;
        resp_rden = 1'b0; resp_open = 1'b1; reg_ack = 1'b0; reg_rdata = 32'h0;

        vt[0] = '{32'h8000_0010, 32'hCAFE_F00D, 3, 32'h0,         32'h4000_0010, 32'hCAFE_F00D};
        vt[1] = '{32'h0000_0020, 32'h0,         1, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678};
        vt[2] = '{32'h0000_0055, 32'h0,        -1, 32'h0,         32'h8000_0055, 32'hDEAD_DEAD};
        vt[3] = '{32'hFF12_3456, 32'h1111_2222, 0, 32'h99,        32'h4012_3456, 32'h1111_2222};
        vt[4] = '{32'h7F00_0001, 32'h0000_AAAA, 0, 32'hBEEF_0001, 32'h0000_0001, 32'hBEEF_0001};

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_req_full", req_full, 0);
        check("rst_resp_empty", resp_empty, 1);
        check("rst_resp_data", resp_data, 0);
        check("rst_reg_valid", reg_valid, 0);
        check("rst_reg_wr", reg_wr, 0);
        check("rst_reg_addr", reg_addr, 0);
        check("rst_reg_wdata", reg_wdata, 0);
        check("rst_timeout_cnt", timeout_cnt, 0);
        check("rst_ovf_cnt", ovf_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_txn(vt[i].w0, vt[i].w1, vt[i].dly, vt[i].rd, 1'b1);
            read_word(d);
            check("tbl_resp0", d, vt[i].e0);
            read_word(d);
            check("tbl_resp1", d, vt[i].e1);
        end
        check("timeout_cnt_1", timeout_cnt, 1);

        prev = resp_data;
        read_word(d);
        check("empty_read_hold", d, prev);
        check("empty_after_drain", resp_empty, 1);

        for (int i = 0; i < 24; i++) begin
            w0  = $urandom;
            w1  = $urandom;
            rd  = $urandom;
            dly = $urandom_range(0, 6);
            run_txn(w0, w1, dly, rd, 1'b1);
            model_push(w0, w1, rd, 1'b0);
            if (exp_q.size() >= 6 || $urandom_range(0, 1) == 1)
                while (exp_q.size() > 0) check_pop("rnd_resp");
        end
        while (exp_q.size() > 0) check_pop("rnd_resp");

        for (int i = 0; i < 8; i++) begin
            w0 = 32'h0000_0100 + 32'(i);
            rd = 32'hA5A5_0000 + 32'(i);
            if (i == 7) check("bp_not_full_7", req_full, 0);
            run_txn(w0, 32'h0, 0, rd, 1'b1);
            model_push(w0, 32'h0, rd, 1'b0);
        end
        check("bp_full_8", req_full, 1);
        req_wren = 1'b1;
        req_data = 32'h8000_0999;
        @(negedge clk);
        req_wren = 1'b0;
        req_data = 32'h0;
        check("bp_ovf_cnt", ovf_cnt, 1);
        check_pop("bp_drain");
        check("bp_full_15", req_full, 1);
        check_pop("bp_drain");
        check("bp_clear_14", req_full, 0);
        while (exp_q.size() > 0) check_pop("bp_drain");

        req_wren = 1'b1;
        req_data = 32'h8000_0AAA;
        @(negedge clk);
        req_wren = 1'b0;
        req_open = 1'b0;
        @(negedge clk);
        req_wren = 1'b1;
        req_data = 32'h8000_0BBB;
        @(negedge clk);
        req_wren = 1'b0;
        req_data = 32'h0;
        check("abort_no_ovf", ovf_cnt, 1);
        check("abort_not_full", req_full, 0);
        req_open = 1'b1;
        @(negedge clk);
        run_txn(32'h0000_0033, 32'h0, 1, 32'h5A5A_0033, 1'b1);
        model_push(32'h0000_0033, 32'h0, 32'h5A5A_0033, 1'b0);
        check_pop("abort_resp0");
        check_pop("abort_resp1");

        resp_open = 1'b0;
        run_txn(32'h8000_0044, 32'h7777_0000, 0, 32'h0, 1'b0);
        check("closed_empty", resp_empty, 1);
        resp_open = 1'b1;
        @(negedge clk);
        check("reopen_empty", resp_empty, 1);

        run_txn(32'h8000_0066, 32'h0BAD_F00D, 2, 32'h0, 1'b1);
        model_push(32'h8000_0066, 32'h0BAD_F00D, 32'h0, 1'b0);
        check_pop("post_close_resp0");
        check_pop("post_close_resp1");

        check("final_timeout_cnt", timeout_cnt, 1);
        check("final_ovf_cnt", ovf_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
